// File: rtl/day20_rsp_buffer.sv
// day20_rsp_buffer: captures read responses from the day20 memory block into a small FIFO
// and re-issues them on a valid/ready stream. Snoops the read strobe to track outstanding
// reads and produces a read-allow credit so the FIFO can always absorb every answer.
//
// Ports:
//   clk, reset     single rising-edge clock, synchronous active-high reset
//   read_req_i     copy of the read strobe driven into day20 (one read per high cycle)
//   rd_valid_i     response strobe from day20, rd_data_i carries the response data
//   rd_allow_o     another read may be issued without risk of overflow
//   out_valid_o    head of FIFO valid, out_data_o is the head data, out_ready_i accepts it
//   level_o        entries currently stored
//   outst_o        reads issued but not yet answered
//   overflow_o     sticky: a response was dropped because the FIFO was full
//   unsol_o        sticky: a response arrived while nothing was outstanding
module day20_rsp_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read_req_i,
    input  logic              rd_valid_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              rd_allow_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    output logic [CNT_W-1:0]  level_o,
    output logic [CNT_W-1:0]  outst_o,
    output logic              overflow_o,
    output logic              unsol_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PtrOne   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] OutstMax = '1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  level_q, level_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              overflow_q, overflow_d;
    logic              unsol_q, unsol_d;

    logic push, pop, push_ok, outst_inc, outst_dec;
    logic [CNT_W:0] credit_sum;

    assign pop     = (level_q != '0) && out_ready_i;
    assign push    = rd_valid_i;
    // When full, a push is only safe if the head leaves in the same cycle.
    assign push_ok = push && ((level_q != DepthCnt) || pop);

    assign outst_inc = read_req_i && (outst_q != OutstMax);
    assign outst_dec = rd_valid_i && (outst_q != '0);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        outst_d    = outst_q;
        head_d     = head_q;
        overflow_d = overflow_q;
        unsol_d    = unsol_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        if (push_ok && !pop) begin
            level_d = level_q + CntOne;
        end else if (pop && !push_ok) begin
            level_d = level_q - CntOne;
        end

        // Registered head copy: the new head is either the incoming word (when the FIFO
        // is or becomes empty behind it) or the next stored entry. Holds when empty.
        if (level_q == '0) begin
            if (push_ok) begin
                head_d = rd_data_i;
            end
        end else if (pop) begin
            if (level_q == CntOne) begin
                if (push_ok) begin
                    head_d = rd_data_i;
                end
            end else begin
                head_d = mem_q[rd_ptr_q + PtrOne];
            end
        end

        if (outst_inc && !outst_dec) begin
            outst_d = outst_q + CntOne;
        end else if (outst_dec && !read_req_i) begin
            outst_d = outst_q - CntOne;
        end

        if (push && !push_ok) begin
            overflow_d = 1'b1;
        end
        if (rd_valid_i && (outst_q == '0)) begin
            unsol_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            outst_q    <= '0;
            head_q     <= '0;
            overflow_q <= 1'b0;
            unsol_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            outst_q    <= outst_d;
            head_q     <= head_d;
            overflow_q <= overflow_d;
            unsol_q    <= unsol_d;
        end
    end

    // Storage needs no reset; level/pointers define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem_q[wr_ptr_q] <= rd_data_i;
        end
    end

    assign credit_sum  = {1'b0, level_q} + {1'b0, outst_q};
    assign rd_allow_o  = credit_sum < (CNT_W + 1)'(DEPTH);
    assign out_valid_o = (level_q != '0);
    assign out_data_o  = head_q;
    assign level_o     = level_q;
    assign outst_o     = outst_q;
    assign overflow_o  = overflow_q;
    assign unsol_o     = unsol_q;

endmodule

// File: tb/tb_day20_rsp_buffer.sv
module tb_day20_rsp_buffer;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              read_req_i;
    logic              rd_valid_i;
    logic [DATA_W-1:0] rd_data_i;
    logic              rd_allow_o;
    logic              out_valid_o;
    logic [DATA_W-1:0] out_data_o;
    logic              out_ready_i;
    logic [CNT_W-1:0]  level_o;
    logic [CNT_W-1:0]  outst_o;
    logic              overflow_o;
    logic              unsol_o;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q [$];

    day20_rsp_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .read_req_i (read_req_i),
        .rd_valid_i (rd_valid_i),
        .rd_data_i  (rd_data_i),
        .rd_allow_o (rd_allow_o),
        .out_valid_o(out_valid_o),
        .out_data_o (out_data_o),
        .out_ready_i(out_ready_i),
        .level_o    (level_o),
        .outst_o    (outst_o),
        .overflow_o (overflow_o),
        .unsol_o    (unsol_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic respond(input logic [DATA_W-1:0] d, input bit expect_kept);
        rd_valid_i = 1'b1;
        rd_data_i  = d;
        if (expect_kept) exp_q.push_back(d);
        tick();
        rd_valid_i = 1'b0;
    endtask

    // Monitor: every handshake on the output stream is checked against the scoreboard.
    always @(negedge clk) begin
        if (!reset && out_valid_o && out_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_data unexpected got=%0h exp=none", out_data_o);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                if (out_data_o !== e) begin
                    errors++;
                    $display("FAIL out_data got=%0h exp=%0h", out_data_o, e);
                end
            end
        end
    end

    initial begin
        reset       = 1'b1;
        read_req_i  = 1'b0;
        rd_valid_i  = 1'b0;
        rd_data_i   = '0;
        out_ready_i = 1'b0;

        // Reset then idle
        tick();
        tick();
        reset = 1'b0;
        chk("rst_out_data", 64'(out_data_o), 64'h0);
        chk("rst_flags", {60'h0, out_valid_o, overflow_o, unsol_o, rd_allow_o}, 64'h1);
        for (int i = 0; i < 10; i++) begin
            chk("idle_cnt", {58'h0, level_o, outst_o}, 64'h0);
            tick();
        end

        // Single read, ready held high
        out_ready_i = 1'b1;
        read_req_i  = 1'b1;
        tick();
        read_req_i = 1'b0;
        chk("single_outst1", 64'(outst_o), 64'd1);
        respond(32'hDEAD_BEEF, 1'b1);
        chk("single_valid", 64'(out_valid_o), 64'd1);
        chk("single_outst0", 64'(outst_o), 64'd0);
        tick();
        chk("single_valid_drop", 64'(out_valid_o), 64'd0);

        // Fill with ready low
        out_ready_i = 1'b0;
        read_req_i  = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        read_req_i = 1'b0;
        chk("fill_outst4", 64'(outst_o), 64'd4);
        chk("fill_allow0", 64'(rd_allow_o), 64'd0);
        for (int i = 1; i <= 4; i++) respond(32'(i), 1'b1);
        chk("fill_level4", 64'(level_o), 64'd4);
        chk("fill_head_hold", 64'(out_data_o), 64'h1);
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        out_ready_i = 1'b0;
        chk("drain_level0", 64'(level_o), 64'd0);
        chk("drain_allow1", 64'(rd_allow_o), 64'd1);

        // Full plus simultaneous events (6 reads so 0x5/0x6 are solicited)
        read_req_i = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        read_req_i = 1'b0;
        for (int i = 1; i <= 4; i++) respond(32'(i), 1'b1);
        respond(32'h5, 1'b0);
        chk("ovf_level4", 64'(level_o), 64'd4);
        chk("ovf_flag", 64'(overflow_o), 64'd1);
        out_ready_i = 1'b1;
        respond(32'h6, 1'b1);
        out_ready_i = 1'b0;
        chk("simul_level4", 64'(level_o), 64'd4);
        chk("simul_unsol0", 64'(unsol_o), 64'd0);
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("simul_level0", 64'(level_o), 64'd0);
        chk("simul_outst0", 64'(outst_o), 64'd0);

        // Unsolicited response
        respond(32'hA5A5_A5A5, 1'b1);
        chk("unsol_flag", 64'(unsol_o), 64'd1);
        chk("unsol_outst0", 64'(outst_o), 64'd0);
        chk("unsol_valid", 64'(out_valid_o), 64'd1);
        tick();
        out_ready_i = 1'b0;

        // Reset mid-operation
        read_req_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        read_req_i = 1'b0;
        for (int i = 0; i < 3; i++) respond(32'h100 + 32'(i), 1'b1);
        chk("mid_cnt", {58'h0, level_o, outst_o}, {58'h0, 3'd3, 3'd1});
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        chk("mid_rst_cnt", {58'h0, level_o, outst_o}, 64'h0);
        chk("mid_rst_flags", {61'h0, out_valid_o, overflow_o, unsol_o}, 64'h0);

        // Stream across pointer wrap
        out_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            read_req_i = 1'b1;
            tick();
            read_req_i = 1'b0;
            respond(32'h1111_1111 * 32'(i + 1), 1'b1);
        end
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        tick();
        chk("wrap_drained", 64'(exp_q.size()), 64'd0);
        chk("wrap_flags", {62'h0, overflow_o, unsol_o}, 64'h0);
        chk("wrap_cnt", {58'h0, level_o, outst_o}, 64'h0);
        chk("wrap_allow", 64'(rd_allow_o), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/day20_rsp_buffer.md
Name: day20_rsp_buffer

Overview:
- Sits directly downstream of the day20 memory block. Captures every read response that day20 presents as a rd_valid_o/rd_data_o pulse.
- Buffers responses in a small FIFO and re-issues them on a valid/ready stream, so that consumers which stall do not lose data.
- Tracks outstanding reads by snooping the read strobe sent to day20. Produces a read-allow credit so upstream never issues more reads than the buffer can absorb.
- Flags overflow and unsolicited responses as sticky errors.

Parameters:
- DATA_W, 32, width of read data (matches day20 rd_data_o).
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, width of level/outstanding counters (derived; do not override).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- read_req_i  input  1  copy of the read_i strobe driven into day20; one read issued per high cycle.
- rd_valid_i  input  1  from day20 rd_valid_o; one response per high cycle.
- rd_data_i  input  DATA_W  from day20 rd_data_o; valid only when rd_valid_i=1.
- rd_allow_o  output  1  high when another read may be issued without risk of overflow.
- out_valid_o  output  1  head of FIFO is valid.
- out_data_o  output  DATA_W  head-of-FIFO data.
- out_ready_i  input  1  consumer accepts head when out_valid_o & out_ready_i.
- level_o  output  CNT_W  number of entries currently stored.
- outst_o  output  CNT_W  reads issued but not yet answered.
- overflow_o  output  1  sticky: a response was dropped because the FIFO was full.
- unsol_o  output  1  sticky: a response arrived with outst_o==0.

Behaviour:
- Reset (reset=1 sampled at posedge) sets the following and discards all FIFO contents:
  - out_valid_o=0, out_data_o=0, level_o=0, outst_o=0.
  - overflow_o=0, unsol_o=0.
  - rd_allow_o=1 (combinational from counters).
- Reset mid-operation behaves identically to reset from idle; in-flight responses arriving after reset deasserts count as unsolicited.
- Push/pop rules:
  - push = rd_valid_i; pop = out_valid_o & out_ready_i.
  - A push is accepted if level_o<DEPTH, or if level_o==DEPTH and pop occurs in the same cycle.
  - Otherwise the push is dropped, FIFO contents are unchanged, and overflow_o sets.
- Latency: a response accepted at edge N gives out_valid_o=1 with that data after edge N (visible in cycle N+1). There is no combinational bypass from rd_data_i to out_data_o.
- Ordering: strict FIFO order; out_data_o is registered/array-read of the head entry and holds stable while out_valid_o=1 and out_ready_i=0.
- Pointers:
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - level_o is a separate counter: +1 on accepted push without pop, -1 on pop without push, unchanged on both or neither.
- Empty: out_valid_o=0. out_ready_i is ignored and out_data_o holds its last value.
- Simultaneous push and pop when empty is impossible, because pop requires out_valid_o=1.
- Outstanding tracker:
  - outst_o +1 on read_req_i; -1 on rd_valid_i when outst_o>0; unchanged if both occur in the same cycle.
  - rd_valid_i with outst_o==0 sets unsol_o. The data is still pushed if space allows, and outst_o stays 0 (no underflow).
  - read_req_i with outst_o at max (2^CNT_W-1) saturates.
- rd_allow_o = (level_o + outst_o) < DEPTH, computed combinationally with CNT_W+1-bit arithmetic.
- Sticky flags clear only on reset.

Test Plan:
- Reset then idle: assert reset 2 cycles, release -> all outputs 0 except rd_allow_o=1; level_o=0, outst_o=0 for 10 cycles.
- Single read, out_ready_i=1 held:
  - read_req_i one cycle -> outst_o=1.
  - rd_valid_i with rd_data_i=0xDEADBEEF -> next cycle out_valid_o=1, out_data_o=0xDEADBEEF, outst_o=0.
  - Following cycle out_valid_o=0.
- Fill with out_ready_i=0, DEPTH=4:
  - 4 reads give outst_o=4 and rd_allow_o=0.
  - Responses 0x1, 0x2, 0x3, 0x4 give level_o=4.
  - Raise out_ready_i -> 0x1..0x4 in order, one per cycle; level_o ends 0 and rd_allow_o returns 1.
- Full plus simultaneous events:
  - At level_o=4 with out_ready_i=0, push 0x5 -> dropped, overflow_o=1, level_o=4.
  - Repeat with out_ready_i=1 and push 0x6 in the same cycle -> accepted, level_o stays 4, 0x6 emerges after 0x2..0x4.
- Unsolicited response: with outst_o=0, pulse rd_valid_i with 0xA5A5A5A5 -> unsol_o=1, outst_o=0, data delivered on output.
- Reset mid-operation and wrap:
  - With level_o=3 and outst_o=1, assert reset one cycle -> level_o=0, flags cleared, out_valid_o=0.
  - Then stream 10 reads/responses with out_ready_i=1 -> data order preserved across pointer wrap, no flags set.
